ctrl_pipeline: RTL

- Consumes the 9 decoded control signals produced in ID and carries them through the ID/EX, EX/MEM and MEM/WB pipeline registers.
- Resolves the destination register and detects load-use hazards, inserting bubbles on a stall.
- Flushes on a taken branch and generates EX-stage forwarding selects.
- Sits between the main controller and the EX/MEM/WB datapath muxes.

---
 rtl/ctrl_pipeline_pkg.sv | 58 +++++
 rtl/ctrl_pipeline_if.sv | 81 ++++++++
 rtl/ctrl_pipeline_hazard_unit.sv | 71 +++++++
 rtl/ctrl_pipeline.sv | 162 ++++++++++++++++
 4 files changed

// File: rtl/ctrl_pipeline_pkg.sv
`default_nettype none
// ============================================================================
// Module   : ctrl_pkg
// Purpose  : Shared constants for the control pipeline: forwarding selects,
//            ALUOp encodings, ID/EX control-word layout and its bubble value.
// Revision : 1.0  initial release
// ============================================================================
package ctrl_pkg;

    // EX operand forwarding selects
    localparam logic [1:0] FWD_NONE   = 2'b00;
    localparam logic [1:0] FWD_WB     = 2'b01;
    localparam logic [1:0] FWD_MEM    = 2'b10;

    // ALUOp encodings driven by the main controller
    localparam logic [1:0] ALUOP_MEM  = 2'b00;
    localparam logic [1:0] ALUOP_BR   = 2'b01;
    localparam logic [1:0] ALUOP_FUNC = 2'b10;

    // RegDst is consumed by destination resolution in ID, so only the other
    // eight controls travel in the ID/EX control word.
    localparam int CTRL_W      = 8;
    localparam int CB_ALUSRC   = 0;
    localparam int CB_MEMREAD  = 1;
    localparam int CB_MEMWRITE = 2;
    localparam int CB_BRANCH   = 3;
    localparam int CB_REGWRITE = 4;
    localparam int CB_MEMTOREG = 5;
    localparam int CB_ALUOP_LO = 6;
    localparam int CB_ALUOP_HI = 7;

    typedef logic [CTRL_W-1:0] ctrl_word_t;

    localparam ctrl_word_t CTRL_BUBBLE = '0;

    function automatic ctrl_word_t pack_ctrl(
        input logic       alusrc,
        input logic       memread,
        input logic       memwrite,
        input logic       branch,
        input logic       regwrite,
        input logic       memtoreg,
        input logic [1:0] aluop
    );
        ctrl_word_t w;
        w                         = CTRL_BUBBLE;
        w[CB_ALUSRC]              = alusrc;
        w[CB_MEMREAD]             = memread;
        w[CB_MEMWRITE]            = memwrite;
        w[CB_BRANCH]              = branch;
        w[CB_REGWRITE]            = regwrite;
        w[CB_MEMTOREG]            = memtoreg;
        w[CB_ALUOP_HI:CB_ALUOP_LO] = aluop;
        return w;
    endfunction

endpackage
`default_nettype wire

// File: rtl/ctrl_pipeline_if.sv
`default_nettype none
// ============================================================================
// Module   : ctrl_pipeline_if
// Purpose  : Bundles the decoded ID controls, the EX branch condition and all
//            per-stage control outputs of the control pipeline.
//            master : main controller / datapath side (drives id_*, cond)
//            slave  : ctrl_pipeline (drives ex_*, mem_*, wb_*, hazard outputs)
// Revision : 1.0  initial release
// ============================================================================
interface ctrl_pipeline_if #(
    parameter int REG_AW = 5
);
    // ID stage inputs
    logic              id_valid;
    logic              id_RegDst;
    logic              id_ALUSrc;
    logic              id_MemtoReg;
    logic              id_RegWrite;
    logic              id_MemRead;
    logic              id_MemWrite;
    logic              id_Branch;
    logic [1:0]        id_ALUOp;
    logic [REG_AW-1:0] id_rs;
    logic [REG_AW-1:0] id_rt;
    logic [REG_AW-1:0] id_rd;
    logic              ex_BranchCond;

    // ID/EX outputs
    logic              ex_ALUSrc;
    logic              ex_MemRead;
    logic              ex_MemWrite;
    logic              ex_Branch;
    logic              ex_RegWrite;
    logic              ex_MemtoReg;
    logic [1:0]        ex_ALUOp;
    logic [REG_AW-1:0] ex_dst;

    // EX/MEM outputs
    logic              mem_MemRead;
    logic              mem_MemWrite;
    logic              mem_RegWrite;
    logic              mem_MemtoReg;
    logic [REG_AW-1:0] mem_dst;
    logic              mem_PCSrc;

    // MEM/WB outputs
    logic              wb_RegWrite;
    logic              wb_MemtoReg;
    logic [REG_AW-1:0] wb_dst;

    // Hazard outputs
    logic [1:0]        ForwardA;
    logic [1:0]        ForwardB;
    logic              Stall;
    logic              IFID_Flush;

    modport master (
        output id_valid, id_RegDst, id_ALUSrc, id_MemtoReg, id_RegWrite,
               id_MemRead, id_MemWrite, id_Branch, id_ALUOp,
               id_rs, id_rt, id_rd, ex_BranchCond,
        input  ex_ALUSrc, ex_MemRead, ex_MemWrite, ex_Branch, ex_RegWrite,
               ex_MemtoReg, ex_ALUOp, ex_dst,
               mem_MemRead, mem_MemWrite, mem_RegWrite, mem_MemtoReg,
               mem_dst, mem_PCSrc,
               wb_RegWrite, wb_MemtoReg, wb_dst,
               ForwardA, ForwardB, Stall, IFID_Flush
    );

    modport slave (
        input  id_valid, id_RegDst, id_ALUSrc, id_MemtoReg, id_RegWrite,
               id_MemRead, id_MemWrite, id_Branch, id_ALUOp,
               id_rs, id_rt, id_rd, ex_BranchCond,
        output ex_ALUSrc, ex_MemRead, ex_MemWrite, ex_Branch, ex_RegWrite,
               ex_MemtoReg, ex_ALUOp, ex_dst,
               mem_MemRead, mem_MemWrite, mem_RegWrite, mem_MemtoReg,
               mem_dst, mem_PCSrc,
               wb_RegWrite, wb_MemtoReg, wb_dst,
               ForwardA, ForwardB, Stall, IFID_Flush
    );
endinterface
`default_nettype wire

// File: rtl/ctrl_pipeline_hazard_unit.sv
`default_nettype none
// ============================================================================
// Module   : hazard_unit
// Purpose  : Combinational hazard logic: load-use stall, IF/ID flush on a taken
//            branch, and EX operand forwarding selects (MEM beats WB).
// Ports    : i_id_*  ID-stage fields, i_ex_* / i_mem_* / i_wb_* stage register
//            contents; o_stall, o_ifid_flush, o_forward_a, o_forward_b.
// Revision : 1.0  initial release
// ============================================================================
module hazard_unit
    import ctrl_pkg::*;
#(
    parameter int REG_AW   = 5,
    parameter int ZERO_REG = 0
) (
    input  wire logic              i_id_valid,
    input  wire logic              i_id_alusrc,
    input  wire logic              i_id_memwrite,
    input  wire logic [REG_AW-1:0] i_id_rs,
    input  wire logic [REG_AW-1:0] i_id_rt,
    input  wire logic              i_ex_memread,
    input  wire logic [REG_AW-1:0] i_ex_dst,
    input  wire logic [REG_AW-1:0] i_ex_rs,
    input  wire logic [REG_AW-1:0] i_ex_rt,
    input  wire logic              i_mem_regwrite,
    input  wire logic [REG_AW-1:0] i_mem_dst,
    input  wire logic              i_mem_pcsrc,
    input  wire logic              i_wb_regwrite,
    input  wire logic [REG_AW-1:0] i_wb_dst,
    output logic                   o_stall,
    output logic                   o_ifid_flush,
    output logic [1:0]             o_forward_a,
    output logic [1:0]             o_forward_b
);

    localparam logic [REG_AW-1:0] c_zero = REG_AW'(ZERO_REG);

    logic w_uses_rt;
    logic w_load_use;

    function automatic logic [1:0] fwd_sel(
        input logic [REG_AW-1:0] src,
        input logic              mem_rw,
        input logic [REG_AW-1:0] mem_dst,
        input logic              wb_rw,
        input logic [REG_AW-1:0] wb_dst
    );
        if (mem_rw && (mem_dst != c_zero) && (mem_dst == src))
            return FWD_MEM;
        else if (wb_rw && (wb_dst != c_zero) && (wb_dst == src))
            return FWD_WB;
        else
            return FWD_NONE;
    endfunction

    // rt is a source operand for register-register ALU ops and for stores.
    assign w_uses_rt  = ~i_id_alusrc | i_id_memwrite;

    assign w_load_use = i_ex_memread & i_id_valid & (i_ex_dst != c_zero) &
                        ((i_ex_dst == i_id_rs) | (w_uses_rt & (i_ex_dst == i_id_rt)));

    // A taken branch squashes the younger instructions anyway, so it masks
    // the stall rather than holding a wrong-path instruction.
    assign o_stall      = w_load_use & ~i_mem_pcsrc;
    assign o_ifid_flush = i_mem_pcsrc;

    assign o_forward_a  = fwd_sel(i_ex_rs, i_mem_regwrite, i_mem_dst, i_wb_regwrite, i_wb_dst);
    assign o_forward_b  = fwd_sel(i_ex_rt, i_mem_regwrite, i_mem_dst, i_wb_regwrite, i_wb_dst);

endmodule
`default_nettype wire

// File: rtl/ctrl_pipeline.sv
`default_nettype none
// ============================================================================
// Module   : ctrl_pipeline
// Purpose  : Carries decoded controls through ID/EX, EX/MEM and MEM/WB,
//            resolves the destination register in ID and applies bubbles on
//            load-use stalls and taken-branch flushes.
// Ports    : Clk, Rst (async, active high), bus (ctrl_pipeline_if.slave):
//            id_* controls in, ex_*/mem_*/wb_* controls out, ForwardA/B,
//            Stall and IFID_Flush out.
// Revision : 1.0  initial release
// ============================================================================
module ctrl_pipeline
    import ctrl_pkg::*;
#(
    parameter int REG_AW   = 5,
    parameter int ZERO_REG = 0
) (
    input  wire logic     Clk,
    input  wire logic     Rst,
    ctrl_pipeline_if.slave bus
);

    localparam logic [REG_AW-1:0] c_zero = REG_AW'(ZERO_REG);

    // ID/EX
    ctrl_word_t        r_ex_ctrl;
    logic [REG_AW-1:0] r_ex_dst;
    logic [REG_AW-1:0] r_ex_rs;
    logic [REG_AW-1:0] r_ex_rt;
    // EX/MEM
    logic              r_mem_memread;
    logic              r_mem_memwrite;
    logic              r_mem_regwrite;
    logic              r_mem_memtoreg;
    logic              r_mem_branch;
    logic              r_mem_cond;
    logic [REG_AW-1:0] r_mem_dst;
    // MEM/WB
    logic              r_wb_regwrite;
    logic              r_wb_memtoreg;
    logic [REG_AW-1:0] r_wb_dst;

    logic              w_stall;
    logic              w_flush;
    logic              w_pcsrc;
    logic [REG_AW-1:0] w_dst_sel;
    logic              w_regwrite;
    logic [REG_AW-1:0] w_dst;
    logic              w_idex_bubble;
    ctrl_word_t        w_id_ctrl;

    // Destination resolution: a non-writing instruction carries dst 0 so a
    // don't-care RegDst can never create a false hazard or forward.
    assign w_dst_sel     = bus.id_RegDst ? bus.id_rd : bus.id_rt;
    assign w_regwrite    = bus.id_RegWrite & (w_dst_sel != c_zero);
    assign w_dst         = w_regwrite ? w_dst_sel : '0;
    assign w_id_ctrl     = pack_ctrl(bus.id_ALUSrc, bus.id_MemRead, bus.id_MemWrite,
                                     bus.id_Branch, w_regwrite, bus.id_MemtoReg,
                                     bus.id_ALUOp);
    assign w_idex_bubble = w_flush | w_stall | ~bus.id_valid;
    assign w_pcsrc       = r_mem_branch & r_mem_cond;

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            r_ex_ctrl <= CTRL_BUBBLE;
            r_ex_dst  <= '0;
            r_ex_rs   <= '0;
            r_ex_rt   <= '0;
        end else if (w_idex_bubble) begin
            r_ex_ctrl <= CTRL_BUBBLE;
            r_ex_dst  <= '0;
            r_ex_rs   <= '0;
            r_ex_rt   <= '0;
        end else begin
            r_ex_ctrl <= w_id_ctrl;
            r_ex_dst  <= w_dst;
            r_ex_rs   <= bus.id_rs;
            r_ex_rt   <= bus.id_rt;
        end
    end

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst || w_flush) begin
            r_mem_memread  <= 1'b0;
            r_mem_memwrite <= 1'b0;
            r_mem_regwrite <= 1'b0;
            r_mem_memtoreg <= 1'b0;
            r_mem_branch   <= 1'b0;
            r_mem_cond     <= 1'b0;
            r_mem_dst      <= '0;
        end else begin
            r_mem_memread  <= r_ex_ctrl[CB_MEMREAD];
            r_mem_memwrite <= r_ex_ctrl[CB_MEMWRITE];
            r_mem_regwrite <= r_ex_ctrl[CB_REGWRITE];
            r_mem_memtoreg <= r_ex_ctrl[CB_MEMTOREG];
            r_mem_branch   <= r_ex_ctrl[CB_BRANCH];
            r_mem_cond     <= bus.ex_BranchCond;
            r_mem_dst      <= r_ex_dst;
        end
    end

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            r_wb_regwrite <= 1'b0;
            r_wb_memtoreg <= 1'b0;
            r_wb_dst      <= '0;
        end else begin
            r_wb_regwrite <= r_mem_regwrite;
            r_wb_memtoreg <= r_mem_memtoreg;
            r_wb_dst      <= r_mem_dst;
        end
    end

    hazard_unit #(
        .REG_AW   (REG_AW),
        .ZERO_REG (ZERO_REG)
    ) u_hazard (
        .i_id_valid     (bus.id_valid),
        .i_id_alusrc    (bus.id_ALUSrc),
        .i_id_memwrite  (bus.id_MemWrite),
        .i_id_rs        (bus.id_rs),
        .i_id_rt        (bus.id_rt),
        .i_ex_memread   (r_ex_ctrl[CB_MEMREAD]),
        .i_ex_dst       (r_ex_dst),
        .i_ex_rs        (r_ex_rs),
        .i_ex_rt        (r_ex_rt),
        .i_mem_regwrite (r_mem_regwrite),
        .i_mem_dst      (r_mem_dst),
        .i_mem_pcsrc    (w_pcsrc),
        .i_wb_regwrite  (r_wb_regwrite),
        .i_wb_dst       (r_wb_dst),
        .o_stall        (w_stall),
        .o_ifid_flush   (w_flush),
        .o_forward_a    (bus.ForwardA),
        .o_forward_b    (bus.ForwardB)
    );

    assign bus.Stall        = w_stall;
    assign bus.IFID_Flush   = w_flush;

    assign bus.ex_ALUSrc    = r_ex_ctrl[CB_ALUSRC];
    assign bus.ex_MemRead   = r_ex_ctrl[CB_MEMREAD];
    assign bus.ex_MemWrite  = r_ex_ctrl[CB_MEMWRITE];
    assign bus.ex_Branch    = r_ex_ctrl[CB_BRANCH];
    assign bus.ex_RegWrite  = r_ex_ctrl[CB_REGWRITE];
    assign bus.ex_MemtoReg  = r_ex_ctrl[CB_MEMTOREG];
    assign bus.ex_ALUOp     = r_ex_ctrl[CB_ALUOP_HI:CB_ALUOP_LO];
    assign bus.ex_dst       = r_ex_dst;

    assign bus.mem_MemRead  = r_mem_memread;
    assign bus.mem_MemWrite = r_mem_memwrite;
    assign bus.mem_RegWrite = r_mem_regwrite;
    assign bus.mem_MemtoReg = r_mem_memtoreg;
    assign bus.mem_dst      = r_mem_dst;
    assign bus.mem_PCSrc    = w_pcsrc;

    assign bus.wb_RegWrite  = r_wb_regwrite;
    assign bus.wb_MemtoReg  = r_wb_memtoreg;
    assign bus.wb_dst       = r_wb_dst;

endmodule
`default_nettype wire
